// File: rtl/pwm_block.sv
// pwm_block: single-channel PWM generator with a CSR slave on the USI bus.
//
// Registers (byte offsets within the selected block):
//   0x00 CTRL   bit0 EN
//   0x04 PERIOD [15:0] period in clock cycles
//   0x08 DUTY   [15:0] high cycles per period
//
// Ports:
//   iSysClk    system clock, rising edge
//   iSysRst    asynchronous active-low reset
//   iSUsiWd    write data
//   iSUsiAdrs  byte address, block field [pBusAdrsBit -: pBlockAdrsMap], offset [7:0]
//   iSUsiWCke  write strobe
//   oSUsiRd    read data (1-cycle latency)
//   oSUsiREd   read data valid
//   oPwm       PWM output
//
// Build option: define PWM_READBACK_EN to enable CSR readback; otherwise
// oSUsiRd/oSUsiREd are tied to 0.
module pwm_block #(
  parameter int pBlockAdrsMap = 8,
  parameter int pAdrsMap      = 2,
  parameter int pBusAdrsBit   = 15
) (
  input  logic        iSysClk,
  input  logic        iSysRst,
  input  logic [31:0] iSUsiWd,
  input  logic [15:0] iSUsiAdrs,
  input  logic        iSUsiWCke,
  output logic [31:0] oSUsiRd,
  output logic        oSUsiREd,
  output logic        oPwm
);

  localparam logic [7:0] OFS_CTRL   = 8'h00;
  localparam logic [7:0] OFS_PERIOD = 8'h04;
  localparam logic [7:0] OFS_DUTY   = 8'h08;

  logic        w_sel;
  logic [7:0]  w_ofs;
  logic        w_wr;
  logic        w_active;
  logic        w_wrap;
  logic        w_unused;

  logic        r_en;
  logic [15:0] r_period;
  logic [15:0] r_duty;
  logic        r_run;
  logic [15:0] r_act_period;
  logic [15:0] r_act_duty;
  logic [15:0] r_cnt;
  logic        r_pwm;

  assign w_sel    = (iSUsiAdrs[pBusAdrsBit -: pBlockAdrsMap] == pBlockAdrsMap'(pAdrsMap));
  assign w_ofs    = iSUsiAdrs[7:0];
  assign w_wr     = iSUsiWCke & w_sel;
  assign w_unused = ^iSUsiWd[31:16];

  // CSR write path
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      r_en     <= 1'b0;
      r_period <= '0;
      r_duty   <= '0;
    end else if (w_wr) begin
      case (w_ofs)
        OFS_CTRL:   r_en     <= iSUsiWd[0];
        OFS_PERIOD: r_period <= iSUsiWd[15:0];
        OFS_DUTY:   r_duty   <= iSUsiWd[15:0];
        default:    ;
      endcase
    end
  end

  // r_run lags EN by one cycle so the counter starts one edge after the
  // enable write and the first high output lands one edge later still.
  // Gating with r_en as well makes a disable take effect on the next edge.
  assign w_active = r_en & r_run & (r_act_period != '0);
  assign w_wrap   = w_active & (r_cnt == r_act_period - 16'd1);

  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      r_run        <= 1'b0;
      r_act_period <= '0;
      r_act_duty   <= '0;
      r_cnt        <= '0;
      r_pwm        <= 1'b0;
    end else begin
      r_run <= r_en;
      // Active copies track the CSRs while idle and are refreshed only at a
      // wrap while running, so a mid-period write never glitches the output.
      if (!w_active || w_wrap) begin
        r_act_period <= r_period;
        r_act_duty   <= r_duty;
        r_cnt        <= '0;
      end else begin
        r_cnt        <= r_cnt + 16'd1;
      end
      r_pwm <= w_active & (r_cnt < r_act_duty);
    end
  end

  assign oPwm = r_pwm;

`ifdef PWM_READBACK_EN
  logic [31:0] w_rd_mux;
  logic [31:0] r_rd;
  logic        r_red;

  always_comb begin
    w_rd_mux = '0;
    case (w_ofs)
      OFS_CTRL:   w_rd_mux = {31'd0, r_en};
      OFS_PERIOD: w_rd_mux = {16'd0, r_period};
      OFS_DUTY:   w_rd_mux = {16'd0, r_duty};
      default:    w_rd_mux = '0;
    endcase
  end

  // A write cycle never produces a read response.
  always_ff @(posedge iSysClk or negedge iSysRst) begin
    if (!iSysRst) begin
      r_rd  <= '0;
      r_red <= 1'b0;
    end else if (w_sel && !iSUsiWCke) begin
      r_rd  <= w_rd_mux;
      r_red <= 1'b1;
    end else begin
      r_rd  <= '0;
      r_red <= 1'b0;
    end
  end

  assign oSUsiRd  = r_rd;
  assign oSUsiREd = r_red;
`else
  assign oSUsiRd  = '0;
  assign oSUsiREd = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_block.sv
module tb_pwm_block;

  logic        iSysClk;
  logic        iSysRst;
  logic [31:0] iSUsiWd;
  logic [15:0] iSUsiAdrs;
  logic        iSUsiWCke;
  logic [31:0] oSUsiRd;
  logic        oSUsiREd;
  logic        oPwm;

  int checks = 0;
  int errors = 0;

`ifdef PWM_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  pwm_block #(
    .pBlockAdrsMap(8),
    .pAdrsMap     (2),
    .pBusAdrsBit  (15)
  ) dut (
    .iSysClk  (iSysClk),
    .iSysRst  (iSysRst),
    .iSUsiWd  (iSUsiWd),
    .iSUsiAdrs(iSUsiAdrs),
    .iSUsiWCke(iSUsiWCke),
    .oSUsiRd  (oSUsiRd),
    .oSUsiREd (oSUsiREd),
    .oPwm     (oPwm)
  );

  initial iSysClk = 1'b0;
  always #5 iSysClk = ~iSysClk;

  task automatic step();
    @(posedge iSysClk);
    #1;
  endtask

  task automatic check_pwm(input logic exp, input string tag);
    checks++;
    assert (oPwm === exp) else begin
      errors++;
      $error("FAIL %s observed oPwm=%b expected %b", tag, oPwm, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    iSUsiAdrs = a;
    iSUsiWd   = d;
    iSUsiWCke = 1'b1;
    step();
    iSUsiWCke = 1'b0;
    iSUsiAdrs = 16'h0000;
    iSUsiWd   = '0;
    checks++;
    assert (oSUsiREd === 1'b0) else begin
      errors++;
      $error("FAIL wr_noread addr=%h observed REd=%b expected 0", a, oSUsiREd);
    end
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [31:0] val, input bit sel,
                          input string tag);
    logic [31:0] exp_rd;
    logic        exp_red;
    exp_red   = RB && sel;
    exp_rd    = exp_red ? val : 32'd0;
    iSUsiAdrs = a;
    iSUsiWCke = 1'b0;
    step();
    iSUsiAdrs = 16'h0000;
    checks++;
    assert (oSUsiRd === exp_rd && oSUsiREd === exp_red) else begin
      errors++;
      $error("FAIL %s observed rd=%0d red=%b expected rd=%0d red=%b",
             tag, oSUsiRd, oSUsiREd, exp_rd, exp_red);
    end
  endtask

  // Steps n edges; at step i the output must reflect counter phase ph0+i.
  task automatic check_wave(input int n, input int per, input int duty, input int ph0,
                            input string tag);
    int   bad;
    int   first;
    logic e;
    bad   = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      step();
      e = (((ph0 + i) % per) < duty);
      if (oPwm !== e || oSUsiREd !== 1'b0 || oSUsiRd !== 32'd0) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    checks++;
    assert (bad === 0) else begin
      errors++;
      $error("FAIL %s observed %0d bad cycles (first at cycle %0d) expected 0", tag, bad, first);
    end
  endtask

  task automatic reconfig(input int per, input int duty);
    bus_write(16'h0200, 32'd0);
    bus_write(16'h0204, per);
    bus_write(16'h0208, duty);
    bus_write(16'h0200, 32'd1);
    step();
    check_pwm(1'b0, "cfg_t1");
  endtask

  initial begin
    iSysRst   = 1'b0;
    iSUsiWd   = '0;
    iSUsiAdrs = 16'h0000;
    iSUsiWCke = 1'b0;

    // Reset
    repeat (5) step();
    checks++;
    assert (oPwm === 1'b0 && oSUsiRd === 32'd0 && oSUsiREd === 1'b0) else begin
      errors++;
      $error("FAIL reset observed pwm=%b rd=%0d red=%b expected 0/0/0", oPwm, oSUsiRd, oSUsiREd);
    end
    iSysRst = 1'b1;
    step();
    bus_read(16'h0200, 32'd0, 1'b1, "rd_ctrl_rst");
    bus_read(16'h0204, 32'd0, 1'b1, "rd_period_rst");
    bus_read(16'h0208, 32'd0, 1'b1, "rd_duty_rst");

    // Configure 100/5 and readback
    bus_write(16'h0204, 32'd100);
    bus_write(16'h0208, 32'd5);
    bus_read(16'h0204, 32'd100, 1'b1, "rd_period");
    bus_read(16'h0208, 32'd5, 1'b1, "rd_duty");
    bus_read(16'h0304, 32'd0, 1'b0, "rd_unsel");

    // Enable: low at T and T+1, first rise at T+2
    bus_write(16'h0200, 32'd1);
    check_pwm(1'b0, "en_t0");
    step();
    check_pwm(1'b0, "en_t1");
    check_wave(8000, 100, 5, 0, "steady_100_5");

    // Mid-period duty update at cnt=20
    check_wave(20, 100, 5, 0, "pre_mid");
    bus_write(16'h0208, 32'd50);
    check_pwm(1'b0, "mid_wr_edge");
    check_wave(79, 100, 5, 21, "mid_cur_period");
    check_wave(300, 100, 50, 0, "mid_next_periods");

    // Write on the wrap edge: old value reloads, new one next wrap
    check_wave(99, 100, 50, 0, "pre_wrap");
    bus_write(16'h0208, 32'd30);
    check_pwm(1'b0, "wrap_wr_edge");
    check_wave(100, 100, 50, 0, "wrap_old_duty");
    check_wave(200, 100, 30, 0, "wrap_new_duty");

    // Boundaries
    reconfig(100, 0);
    check_wave(300, 100, 0, 0, "duty0");
    reconfig(100, 120);
    check_wave(300, 100, 120, 0, "duty_ge_period");
    reconfig(0, 5);
    check_wave(200, 1, 0, 0, "period0");

    // Disable at cnt=2, then re-enable from cnt=0
    reconfig(100, 5);
    check_wave(2, 100, 5, 0, "pre_dis");
    bus_write(16'h0200, 32'd0);
    check_pwm(1'b1, "dis_edge");
    step();
    check_pwm(1'b0, "dis_next");
    check_wave(20, 1, 0, 0, "dis_hold");
    bus_write(16'h0200, 32'd1);
    check_pwm(1'b0, "reen_t0");
    step();
    check_pwm(1'b0, "reen_t1");
    check_wave(250, 100, 5, 0, "reenable");

    // Address decode: foreign block write ignored, upper PERIOD bits dropped
    bus_write(16'h0200, 32'd0);
    bus_read(16'h0200, 32'd0, 1'b1, "rd_ctrl_off");
    bus_write(16'h0204, 32'hABCD_0064);
    bus_write(16'h0304, 32'd7);
    bus_read(16'h0204, 32'd100, 1'b1, "rd_period_decode");
    bus_read(16'h0304, 32'd0, 1'b0, "rd_foreign");
    bus_write(16'h0200, 32'd1);
    step();
    check_pwm(1'b0, "dec_t1");
    check_wave(300, 100, 5, 0, "decode_period");

    // Asynchronous reset mid-operation
    reconfig(100, 120);
    check_wave(10, 100, 120, 0, "pre_async_rst");
    #2 iSysRst = 1'b0;
    #1;
    checks++;
    assert (oPwm === 1'b0 && oSUsiRd === 32'd0 && oSUsiREd === 1'b0) else begin
      errors++;
      $error("FAIL async_rst observed pwm=%b rd=%0d red=%b expected 0/0/0", oPwm, oSUsiRd, oSUsiREd);
    end
    step();
    step();
    iSysRst = 1'b1;
    step();
    bus_read(16'h0204, 32'd0, 1'b1, "rd_period_post_rst");
    check_wave(50, 1, 0, 0, "post_rst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_block.md
# pwm_block

Single-channel PWM generator with a slave CSR port on the system USI bus. Software programs period, duty and enable through three 32-bit registers; the block drives one PWM output, e.g. an audio/LED drive pin. It sits on the processor bus as one slave block, selected by an upper address field.

## Interface
- pBlockAdrsMap, 8: width of the block-select address field.
- pAdrsMap, 2: block-select value this slave answers to.
- pBusAdrsBit, 15: MSB index of the bus address; the block field is iSUsiAdrs[pBusAdrsBit -: pBlockAdrsMap].

- iSysClk  in  1  system clock, all logic on rising edge.
- iSysRst  in  1  reset, asynchronous assert, active-low.
- iSUsiWd  in  32  write data.
- iSUsiAdrs  in  16  byte address; block field [15:8], register offset [7:0].
- iSUsiWCke  in  1  write strobe, one cycle per write.
- oSUsiRd  out  32  read data.
- oSUsiREd  out  1  read-data valid.
- oPwm  out  1  PWM output.

## Operation
- Select: block field == pAdrsMap. Unselected writes are ignored. For the defaults, the registers are at 0x0200, 0x0204 and 0x0208.
- Register 0x00 CTRL: bit0 EN. Other bits read 0.
- Register 0x04 PERIOD: [15:0], in clock cycles. Bits [31:16] are ignored on write and read 0.
- Register 0x08 DUTY: [15:0], the number of high cycles per period.
- Other offsets: writes are ignored; reads return 0.
- Write: when iSUsiWCke=1, the block is selected and the offset is valid, the register loads iSUsiWd at that edge.
- Active copies: actPeriod and actDuty are loaded from the CSRs whenever the block is idle (EN=0) and at each period wrap. Changes written mid-period therefore take effect from the next period; the current period is never glitched.
- Counter cnt[15:0]:
  - Runs only when EN=1 and actPeriod≠0.
  - Increments by 1 each cycle; at actPeriod−1 it wraps to 0 and reloads the active copies.
  - When EN=0 it is held at 0.
- Output: oPwm is registered as (running && cnt < actDuty).
- Boundary cases:
  - actDuty=0: oPwm is constantly 0.
  - actDuty≥actPeriod: oPwm is constantly 1 while running.
  - actPeriod=0: counter stopped, oPwm=0.
- Disable (EN cleared): the counter resets to 0 and oPwm drops to 0 on the next edge, regardless of phase.

## Timing
- Reset values: all CSRs 0, cnt 0, oPwm 0, oSUsiRd 0, oSUsiREd 0.
- A write sampled at edge T is visible in the CSR after T.
- EN set at edge T:
  - Edge T+1: active copies loaded, counter starts at 0.
  - Edge T+2: first oPwm high (when duty>0).
- Steady state: oPwm is high for exactly DUTY cycles out of every PERIOD cycles.
- Readback: registered with 1-cycle latency.
  - The address is sampled every cycle when iSUsiWCke=0 and the block is selected.
  - On the next edge, oSUsiRd holds that register and oSUsiREd=1.
  - Otherwise oSUsiREd=0 and oSUsiRd=0.
- Write/read priority: a write cycle produces no read response.
- Simultaneous write and wrap: the wrap reloads the pre-write CSR value; the newly written value takes effect at the following wrap.
- Asynchronous reset mid-operation: all state clears immediately and oPwm=0.

## Configuration
- PWM_READBACK_EN defined: CSR readback via oSUsiRd/oSUsiREd exactly as described above.
- Not defined: oSUsiRd is tied to 0 and oSUsiREd to 0; the readback mux and registers are removed. The write path and PWM behaviour are unchanged.

## Test plan
- Reset: hold iSysRst=0 for 5 cycles -> all outputs 0; reads of 0x0200, 0x0204 and 0x0208 return 0 after release.
- Write PERIOD=100 (0x0204), DUTY=5 (0x0208), then CTRL=1 (0x0200) -> oPwm is high for 5 cycles and low for 95, repeating with period 100 for at least 80 periods; the first rise occurs 2 edges after the CTRL write edge.
- Mid-period update: while running at 100/5, write DUTY=50 at cnt=20 -> the current period still has 5 high cycles; the next and later periods have 50.
- Boundaries:
  - DUTY=0 -> oPwm is always 0.
  - DUTY=120 with PERIOD=100 -> oPwm is always 1.
  - PERIOD=0 -> oPwm is 0 and the counter is stopped.
- Disable/address decode:
  - Write CTRL=0 at cnt=2 -> oPwm is 0 on the next edge; re-enable restarts from cnt=0.
  - A write to 0x0304 leaves PERIOD unchanged.
- Readback (PWM_READBACK_EN): present 0x0204 -> one cycle later oSUsiRd=100 and oSUsiREd=1; present 0x0304 -> oSUsiREd stays 0. Without the macro, both outputs stay 0 at all times.
